// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback,
// latches immediate-format and ALU controls at DECODE, counts retirements.
module multicycle_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_ifetch,
  output logic [1:0]           imm_sel,
  output logic [11:0]          imm_hi,
  output logic [4:0]           imm_lo,
  output logic                 alu_src_imm,
  output logic [3:0]           alu_op,
  output logic                 reg_we,
  output logic                 wb_sel,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [1:0] {K_ALU, K_LOAD, K_STORE, K_BR} kind_t;

  state_t state;
  kind_t  kind;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        d_ok, d_src, d_wb;
  kind_t       d_kind;
  logic [1:0]  d_sel;
  logic [3:0]  d_op;
  logic [11:0] d_hi;
  logic        unused_rs1;

  assign opc        = instr[6:0];
  assign f3         = instr[14:12];
  assign unused_rs1 = ^instr[19:15];

  always_comb begin
    d_ok   = 1'b1;
    d_kind = K_ALU;
    d_sel  = 2'b00;
    d_op   = 4'b0000;
    d_src  = 1'b0;
    d_wb   = 1'b0;
    d_hi   = instr[31:20];
    case (opc)
      OP_R: d_op = {instr[30], f3};
      OP_I: begin
        d_src = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          d_sel = 2'b10;
          d_op  = {instr[30], f3};
        end else begin
          d_op = {1'b0, f3};
        end
      end
      OP_LD: begin
        d_kind = K_LOAD;
        d_src  = 1'b1;
        d_wb   = 1'b1;
      end
      OP_ST: begin
        d_kind = K_STORE;
        d_sel  = 2'b01;
        d_src  = 1'b1;
        d_hi   = {instr[31], instr[30:25], 5'b0};
      end
      OP_BR: begin
        d_kind = K_BR;
        d_sel  = 2'b11;
        d_op   = 4'b1000;
        d_hi   = {instr[31], instr[30:25], 5'b0};
      end
      default: d_ok = 1'b0;
    endcase
  end

  // Strobes are gated by rst_n so nothing fires while reset is held.
  always_comb begin
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_ifetch = 1'b0;
    reg_we     = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_req    = 1'b1;
          mem_ifetch = 1'b1;
          ir_we      = mem_ready;
        end
        EXEC: if (kind == K_BR) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken;
        end
        MEM: begin
          mem_req = 1'b1;
          mem_we  = (kind == K_STORE);
          pc_we   = (kind == K_STORE) && mem_ready;
        end
        WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Every retirement path updates the PC exactly once, so pc_we marks retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      kind        <= K_ALU;
      imm_sel     <= 2'b00;
      imm_hi      <= 12'h000;
      imm_lo      <= 5'h00;
      alu_op      <= 4'h0;
      alu_src_imm <= 1'b0;
      wb_sel      <= 1'b0;
      illegal     <= 1'b0;
      instret     <= '0;
    end else begin
      if (pc_we) instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
      case (state)
        FETCH: if (mem_ready) state <= DECODE;
        DECODE: begin
          imm_sel     <= d_sel;
          imm_hi      <= d_hi;
          imm_lo      <= instr[11:7];
          alu_op      <= d_op;
          alu_src_imm <= d_src;
          wb_sel      <= d_wb;
          kind        <= d_kind;
          if (d_ok) begin
            state <= EXEC;
          end else begin
            illegal <= 1'b1;
            state   <= HALT;
          end
        end
        EXEC: begin
          case (kind)
            K_ALU:            state <= WB;
            K_LOAD, K_STORE:  state <= MEM;
            default:          state <= FETCH;
          endcase
        end
        MEM:     if (mem_ready) state <= (kind == K_STORE) ? FETCH : WB;
        WB:      state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I datapath.
- Sequences fetch/decode/execute/memory/writeback over shared ALU, memory port and register file.
- Drives the immediate generator's 2-bit format select and routes the instruction's immediate fields.
- Counts retired instructions; halts on unsupported opcodes.

Parameters:
- INSTRET_W, 32, width of retired-instruction counter (wraps modulo 2^INSTRET_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  instruction register contents (valid from DECODE onward).
- mem_ready  in  1  memory port handshake: access completes in the cycle it is high while mem_req is high.
- branch_taken  in  1  ALU compare result, valid in EXEC.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC update.
- pc_sel  out  1  0 = PC+4, 1 = PC+branch offset.
- mem_req  out  1  memory access request.
- mem_we  out  1  store (1) / read (0).
- mem_ifetch  out  1  request is an instruction fetch.
- imm_sel  out  2  immediate format: 00 I/load, 01 S, 10 shift-imm, 11 B.
- imm_hi  out  12  instr[31:20] for I/shift, {instr[31], instr[30:25], 5'b0} for S/B.
- imm_lo  out  5  instr[11:7].
- alu_src_imm  out  1  ALU operand B = immediate.
- alu_op  out  4  ALU operation code.
- reg_we  out  1  register file write.
- wb_sel  out  1  0 = ALU result, 1 = load data.
- illegal  out  1  sticky illegal-instruction flag.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n low):
  - state = FETCH.
  - imm_sel, alu_op, imm_hi, imm_lo, instret = 0.
  - illegal, alu_src_imm, wb_sel = 0.
  - Takes effect immediately, including mid-access; an outstanding memory request is abandoned.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Outputs: mem_req = 1, mem_ifetch = 1, mem_we = 0.
  - ir_we = mem_ready (combinational).
  - mem_ready = 1 -> DECODE; otherwise stay.
- DECODE: one cycle; registers imm_sel, imm_hi, imm_lo, alu_op, alu_src_imm, wb_sel from instr.
  - Opcode 0110011 (R): imm_sel 00, alu_src_imm 0, alu_op = {instr[30], funct3}.
  - Opcode 0010011 (I-ALU): alu_src_imm 1.
    - funct3 001/101: imm_sel 10, alu_op = {instr[30], funct3}.
    - Other funct3: imm_sel 00, alu_op = {0, funct3}.
  - Opcode 0000011 (load): imm_sel 00, alu_src_imm 1, alu_op 0000, wb_sel 1.
  - Opcode 0100011 (store): imm_sel 01, alu_src_imm 1, alu_op 0000.
  - Opcode 1100011 (branch): imm_sel 11, alu_src_imm 0, alu_op 1000.
  - Any other opcode: illegal <= 1, next = HALT; registered fields still update.
  - Supported opcode -> EXEC.
- EXEC:
  - R / I-ALU -> WB.
  - Load / store -> MEM.
  - Branch: pc_we = 1, pc_sel = branch_taken, instret + 1, -> FETCH.
- MEM:
  - Outputs: mem_req = 1, mem_ifetch = 0, mem_we = 1 for store.
  - Wait while mem_ready = 0.
  - Store: on mem_ready, pc_we = 1, pc_sel = 0, instret + 1, -> FETCH.
  - Load: on mem_ready -> WB.
- WB: reg_we = 1, pc_we = 1, pc_sel = 0, instret + 1, -> FETCH.
- HALT: all strobes 0; illegal stays 1; exit only via reset.
- Strobes (ir_we, pc_we, mem_req, mem_we, reg_we) default to 0 outside the states listed.
- Strobes are never asserted in the same cycle as reset deassertion edge effects; first FETCH request appears in the first cycle after rst_n rises.
- mem_ready is ignored when mem_req = 0.
- instret wraps from all-ones to 0 without a flag.
- Latency with mem_ready tied 1:
  - R/I-ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.

Test Plan:
- rst_n low mid-MEM of a load, mem_ready = 0 -> state FETCH, all strobes 0, instret 0 in the same cycle; mem_req = 1 in FETCH the cycle after release.
- instr 0x00500093 (addi x1,x0,5), mem_ready = 1:
  - imm_sel 00, imm_hi 0x005, alu_src_imm 1, alu_op 0000.
  - reg_we in cycle 4, instret 1.
- instr 0x00209193 (slli x3,x1,2) -> imm_sel 10, imm_hi 0x002, alu_op 0001.
- instr 0x00112223 (sw x1,4(x2)), mem_ready low 3 cycles in MEM:
  - imm_sel 01, imm_lo 0x04, imm_hi 0x000.
  - mem_we = 1 held 4 cycles, reg_we never asserted, pc_we once.
- instr 0x00000463 (beq):
  - branch_taken = 1 -> imm_sel 11, imm_lo 0x08, pc_sel 1 with pc_we in EXEC.
  - branch_taken = 0 -> pc_sel 0.
  - 3 cycles per instruction either way.
- instr 0x0000006F (JAL, unsupported) -> illegal 1 after DECODE, HALT; 10 further cycles with mem_ready = 1 produce no strobes; instret unchanged.
